// File: rtl/btn_event_pkg.sv
// Shared definitions for the pushbutton event generator.
//   - event type encodings carried on evt_type
//   - per-button FSM state encoding
//   - event FIFO depth and event word layout (btn index + type)
//   - saturating increment used by the hold counters
package btn_event_pkg;

    localparam int NUM_BTN    = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int EVT_W      = 5;
    localparam int CNT_W      = 16;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;
    localparam logic [1:0] EVT_REPEAT  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    typedef struct packed {
        logic [2:0] btn;
        logic [1:0] etype;
    } evt_t;

    // Hold counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_event_fifo.sv
// First-word-fall-through FIFO for button events.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : consume head entry (ignored when empty)
//   dout         : head entry, valid whenever empty=0
//   full, empty  : occupancy flags
module btn_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Pushbutton event generator: turns debounced button levels into a stream
// of PRESS / RELEASE / LONG / REPEAT events delivered through a small FIFO.
//   clk, reset_n  : clock, asynchronous active-low reset
//   pbtn_db[5:0]  : debounced buttons, 1 = pressed
//   evt_ready     : consumer takes the head event
//   ovf_clr       : one-cycle pulse clearing evt_overflow
//   evt_valid     : head event available
//   evt_btn/type  : head event button index and type
//   evt_overflow  : sticky, an event was dropped at a busy slot
// Pipeline: edge -> registered emit -> per-button slot -> FIFO, giving a
// two-clock PRESS latency when nothing else is queued.
module btn_event_gen
    import btn_event_pkg::*;
#(
    parameter int                 CLK_FREQUENCY_HZ  = 100000000,
    parameter int                 TICK_FREQUENCY_HZ = 1000,
    parameter int                 LONG_PRESS_TICKS  = 1000,
    parameter int                 REPEAT_RATE_TICKS = 100,
    parameter logic [NUM_BTN-1:0] BTN_MASK          = 6'b111110,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK       = 6'b011110,
    parameter int                 SIMULATE          = 0,
    parameter int                 SIMULATE_TICK_CNT = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] pbtn_db,
    input  logic               evt_ready,
    input  logic               ovf_clr,
    output logic               evt_valid,
    output logic [2:0]         evt_btn,
    output logic [1:0]         evt_type,
    output logic               evt_overflow
);
    localparam int TICK_DIV = (SIMULATE != 0) ? SIMULATE_TICK_CNT
                                              : CLK_FREQUENCY_HZ / TICK_FREQUENCY_HZ;
    localparam int DIV_W    = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]        div_cnt;
    logic                    tick;
    logic [NUM_BTN-1:0]      prev_db, rise, fall;
    logic [NUM_BTN-1:0]      em_v;
    logic [NUM_BTN-1:0][1:0] em_t;
    logic [NUM_BTN-1:0]      slot_v, slot_v_d, slot_clr, drop;
    logic [NUM_BTN-1:0][1:0] slot_t, slot_t_d;
    logic [2:0]              push_idx;
    logic                    do_push, pop, fifo_full, fifo_empty;
    evt_t                    push_evt, head;

    // ---- tick divider and edge detect ----
    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign rise = pbtn_db & ~prev_db;
    assign fall = ~pbtn_db & prev_db;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            prev_db <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            prev_db <= pbtn_db;
        end
    end

    // ---- per-button FSM; the emitted event is registered before the slot ----
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [1:0]       st_q, st_d, et_q, et_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
        logic             em_q, em_d;

        always_comb begin
            st_d    = st_q;
            cnt_d   = cnt_q;
            em_d    = 1'b0;
            et_d    = EVT_PRESS;
            cnt_inc = sat_inc(cnt_q);
            if (BTN_MASK[i]) begin
                if (st_q == ST_IDLE) begin
                    if (rise[i]) begin
                        st_d  = ST_HELD;
                        cnt_d = '0;
                        em_d  = 1'b1;
                    end
                end else if (fall[i]) begin
                    // Release wins over a LONG/REPEAT falling due this cycle.
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                    em_d  = 1'b1;
                    et_d  = EVT_RELEASE;
                end else if (tick) begin
                    if (st_q == ST_HELD && int'(cnt_inc) >= LONG_PRESS_TICKS) begin
                        st_d  = ST_LONG;
                        cnt_d = '0;
                        em_d  = 1'b1;
                        et_d  = EVT_LONG;
                    end else if (st_q == ST_LONG && int'(cnt_inc) >= REPEAT_RATE_TICKS) begin
                        cnt_d = '0;
                        em_d  = REPEAT_MASK[i];
                        et_d  = EVT_REPEAT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st_q  <= ST_IDLE;
                cnt_q <= '0;
                em_q  <= 1'b0;
                et_q  <= EVT_PRESS;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                em_q  <= em_d;
                et_q  <= et_d;
            end
        end

        assign em_v[i] = em_q;
        assign em_t[i] = et_q;
    end

    // ---- pending slots, lowest index drains first ----
    assign pop = evt_valid && evt_ready;

    always_comb begin
        push_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (slot_v[i]) push_idx = 3'(i);
        do_push = (|slot_v) && (!fifo_full || pop);
        slot_clr = '0;
        drop     = '0;
        slot_v_d = '0;
        slot_t_d = slot_t;
        for (int i = 0; i < NUM_BTN; i++) begin
            slot_clr[i] = do_push && (push_idx == 3'(i));
            // A slot emptied this cycle can take the new event without loss.
            drop[i]     = em_v[i] && slot_v[i] && !slot_clr[i];
            slot_v_d[i] = em_v[i] || (slot_v[i] && !slot_clr[i]);
            if (em_v[i] && !drop[i]) slot_t_d[i] = em_t[i];
        end
        push_evt.btn   = push_idx;
        push_evt.etype = slot_t[push_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_v       <= '0;
            slot_t       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            slot_v <= slot_v_d;
            slot_t <= slot_t_d;
            if (|drop)        evt_overflow <= 1'b1;
            else if (ovf_clr) evt_overflow <= 1'b0;
        end
    end

    btn_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (do_push),
        .din     (push_evt),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_btn   = head.btn;
    assign evt_type  = head.etype;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: directed scenarios plus a random phase, compared
// every cycle against an event-level reference model (per-button phase and
// tick tally, pending slots, and a queue standing in for the FIFO).
module tb_btn_event_gen;
    import btn_event_pkg::*;

    localparam int         LP    = 4;
    localparam int         RP    = 2;
    localparam int         TDIV  = 5;
    localparam logic [5:0] BMASK = 6'b111110;
    localparam logic [5:0] RMASK = 6'b011110;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] pbtn_db = '0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [2:0] evt_btn;
    logic [1:0] evt_type;
    logic       evt_overflow;

    int errs = 0;
    int checks = 0;

    btn_event_gen #(
        .CLK_FREQUENCY_HZ (100000000),
        .TICK_FREQUENCY_HZ(1000),
        .LONG_PRESS_TICKS (LP),
        .REPEAT_RATE_TICKS(RP),
        .BTN_MASK         (BMASK),
        .REPEAT_MASK      (RMASK),
        .SIMULATE         (1),
        .SIMULATE_TICK_CNT(TDIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pbtn_db     (pbtn_db),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_btn     (evt_btn),
        .evt_type    (evt_type),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    // reference model state
    int m_mode[6];   // 0 released, 1 held, 2 long-held
    int m_ticks[6];  // ticks since press / last long-or-repeat event
    bit m_prev[6];
    bit m_em_v[6];
    int m_em_t[6];
    bit m_sl_v[6];
    int m_sl_t[6];
    int m_q[$];      // btn*4 + type
    bit m_ovf;
    int m_cyc;       // clocks since reset release

    int ev_cnt[8][4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int b = 0; b < 6; b++) begin
            m_mode[b] = 0; m_ticks[b] = 0; m_prev[b] = 0;
            m_em_v[b] = 0; m_em_t[b] = 0; m_sl_v[b] = 0; m_sl_t[b] = 0;
        end
        m_q.delete();
        m_ovf = 0;
        m_cyc = 0;
    endtask

    task automatic mdl_step();
        bit n_em_v[6];
        int n_em_t[6];
        bit tk, pop, push, drop;
        int pb;
        tk = (m_cyc % TDIV) == TDIV - 1;
        for (int b = 0; b < 6; b++) begin
            bit now;
            now = pbtn_db[b];
            n_em_v[b] = 0;
            n_em_t[b] = 0;
            if (BMASK[b]) begin
                if (m_mode[b] == 0) begin
                    if (now && !m_prev[b]) begin
                        m_mode[b] = 1; m_ticks[b] = 0; n_em_v[b] = 1; n_em_t[b] = 0;
                    end
                end else if (!now && m_prev[b]) begin
                    m_mode[b] = 0; m_ticks[b] = 0; n_em_v[b] = 1; n_em_t[b] = 1;
                end else if (tk) begin
                    m_ticks[b]++;
                    if (m_mode[b] == 1 && m_ticks[b] >= LP) begin
                        m_mode[b] = 2; m_ticks[b] = 0; n_em_v[b] = 1; n_em_t[b] = 2;
                    end else if (m_mode[b] == 2 && m_ticks[b] >= RP) begin
                        m_ticks[b] = 0; n_em_v[b] = RMASK[b]; n_em_t[b] = 3;
                    end
                end
            end
        end
        pop = (m_q.size() > 0) && evt_ready;
        pb = -1;
        for (int b = 5; b >= 0; b--) if (m_sl_v[b]) pb = b;
        push = (pb >= 0) && (m_q.size() < 4 || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(pb * 4 + m_sl_t[pb]);
            m_sl_v[pb] = 0;
        end
        drop = 0;
        for (int b = 0; b < 6; b++) begin
            if (m_em_v[b]) begin
                if (m_sl_v[b]) drop = 1;
                else begin m_sl_v[b] = 1; m_sl_t[b] = m_em_t[b]; end
            end
        end
        if (drop) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        for (int b = 0; b < 6; b++) begin
            m_em_v[b] = n_em_v[b];
            m_em_t[b] = n_em_t[b];
            m_prev[b] = pbtn_db[b];
        end
        m_cyc++;
    endtask

    // One clock: tally the handshake, advance model, compare after the edge.
    task automatic step();
        if (evt_valid && evt_ready) ev_cnt[evt_btn][evt_type]++;
        @(posedge clk);
        if (reset_n) mdl_step(); else mdl_reset();
        @(negedge clk);
        chk("valid", evt_valid, m_q.size() > 0);
        if (m_q.size() > 0) chk("head", {evt_btn, evt_type}, m_q[0]);
        chk("ovf", evt_overflow, m_ovf);
    endtask

    task automatic clr_cnt();
        for (int b = 0; b < 8; b++)
            for (int t = 0; t < 4; t++) ev_cnt[b][t] = 0;
    endtask

    function automatic int total_cnt();
        int s = 0;
        for (int b = 0; b < 8; b++)
            for (int t = 0; t < 4; t++) s += ev_cnt[b][t];
        return s;
    endfunction

    initial begin
        mdl_reset();
        clr_cnt();
        repeat (2) @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_btn", evt_btn, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_ovf", evt_overflow, 0);
        reset_n = 1'b1;

        // single press/release, latency
        evt_ready = 1'b1;
        pbtn_db[2] = 1'b1;
        step(); step();
        chk("lat_early", evt_valid, 0);
        step();
        chk("lat_valid", evt_valid, 1);
        chk("press_btn", evt_btn, 2);
        chk("press_type", evt_type, EVT_PRESS);
        repeat (3) step();
        pbtn_db[2] = 1'b0;
        repeat (3) step();
        chk("rel_btn", evt_btn, 2);
        chk("rel_type", evt_type, EVT_RELEASE);
        repeat (3) step();

        // long hold with and without auto-repeat
        clr_cnt();
        pbtn_db[3] = 1'b1;
        pbtn_db[5] = 1'b1;
        repeat (60) step();
        pbtn_db[3] = 1'b0;
        pbtn_db[5] = 1'b0;
        repeat (8) step();
        chk("b3_long", ev_cnt[3][2], 1);
        chk("b3_rpt_ge2", ev_cnt[3][3] >= 2, 1);
        chk("b5_long", ev_cnt[5][2], 1);
        chk("b5_no_rpt", ev_cnt[5][3], 0);
        chk("b5_rel", ev_cnt[5][1], 1);

        // simultaneous presses: lower index first; btn0 silent
        pbtn_db[1] = 1'b1;
        pbtn_db[4] = 1'b1;
        repeat (3) step();
        chk("ord_first", evt_btn, 1);
        step();
        chk("ord_second", evt_btn, 4);
        chk("ord_type", evt_type, EVT_PRESS);
        pbtn_db[1] = 1'b0;
        pbtn_db[4] = 1'b0;
        repeat (6) step();
        clr_cnt();
        for (int k = 0; k < 12; k++) begin
            pbtn_db[0] = ~pbtn_db[0];
            step();
        end
        pbtn_db[0] = 1'b0;
        repeat (4) step();
        chk("b0_quiet", total_cnt(), 0);

        // backpressure, slot overflow, clear
        evt_ready = 1'b0;
        pbtn_db[4:1] = 4'hF;
        repeat (6) step();
        chk("full_valid", evt_valid, 1);
        chk("full_head", evt_btn, 1);
        pbtn_db[4:1] = 4'h0;
        repeat (4) step();
        chk("bp_head", {evt_btn, evt_type}, {3'd1, EVT_PRESS});
        pbtn_db[1] = 1'b1;
        repeat (4) step();
        chk("ovf_set", evt_overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", evt_overflow, 0);
        evt_ready = 1'b1;
        pbtn_db[1] = 1'b0;
        repeat (15) step();

        // reset during long hold with events queued
        evt_ready = 1'b0;
        pbtn_db[2] = 1'b1;
        repeat (40) step();
        chk("pre_rst_valid", evt_valid, 1);
        reset_n = 1'b0;
        step();
        chk("mid_rst_valid", evt_valid, 0);
        step();
        reset_n = 1'b1;
        evt_ready = 1'b1;
        clr_cnt();
        repeat (3) step();
        chk("rst_press_btn", evt_btn, 2);
        chk("rst_press_type", evt_type, EVT_PRESS);
        repeat (8) step();
        chk("rst_single", ev_cnt[2][0], 1);
        chk("rst_only", total_cnt(), 1);
        pbtn_db[2] = 1'b0;
        repeat (6) step();

        // random phase
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 39) == 0) pbtn_db[b] = ~pbtn_db[b];
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/btn_event_gen.md
BTN_EVENT_GEN -- requirements
Module: btn_event_gen

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY_HZ, default 100000000, meaning input clock frequency.
REQ-002 SHALL have parameter TICK_FREQUENCY_HZ, default 1000, meaning hold-timer tick rate.
REQ-003 SHALL have parameter LONG_PRESS_TICKS, default 1000, meaning ticks held before a LONG event.
REQ-004 SHALL have parameter REPEAT_RATE_TICKS, default 100, meaning ticks between REPEAT events after LONG.
REQ-005 SHALL have parameter BTN_MASK, default 6'b111110, meaning buttons that generate events (bit 0, CPU reset, excluded).
REQ-006 SHALL have parameter REPEAT_MASK, default 6'b011110, meaning buttons allowed to auto-repeat.
REQ-007 SHALL have parameters SIMULATE (default 0) and SIMULATE_TICK_CNT (default 5), meaning a shortened tick divider for simulation.
REQ-008 SHALL have the following ports: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pbtn_db  input  6  debounced pushbuttons, 1 = pressed
- evt_ready  input  1  consumer accepts head event
- ovf_clr  input  1  one-cycle pulse, clears evt_overflow
- evt_valid  output  1  head event available
- evt_btn  output  3  button index of head event
- evt_type  output  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- evt_overflow  output  1  sticky, an event was dropped

Function
REQ-009 SHALL generate a one-cycle tick every TICK_DIV clocks, where TICK_DIV = SIMULATE ? SIMULATE_TICK_CNT : CLK_FREQUENCY_HZ/TICK_FREQUENCY_HZ; the divider counts 0..TICK_DIV-1 and wraps.
REQ-010 SHALL register pbtn_db into prev_db each cycle and detect edges as pbtn_db xor prev_db; masked-off buttons never produce events.
REQ-011 SHALL run one FSM per enabled button: IDLE, HELD, LONG.
- IDLE -> HELD on rising edge; emit PRESS; clear hold counter.
- HELD: count ticks; at LONG_PRESS_TICKS -> LONG; emit LONG; clear counter.
- LONG: count ticks; at REPEAT_RATE_TICKS emit REPEAT if REPEAT_MASK bit set; clear counter; stay LONG.
- HELD/LONG -> IDLE on falling edge; emit RELEASE; this takes precedence over a same-cycle LONG/REPEAT, which is discarded.
REQ-012 SHALL hold hold counters at 16 bits, saturating, never wrapping.
REQ-013 SHALL give each button one pending-event slot, set the cycle after the FSM emits.
REQ-014 SHALL drop any event emitted while that button's slot is still occupied, and set evt_overflow the next cycle.
REQ-015 SHALL push the lowest-index pending slot into a 4-entry first-word-fall-through FIFO each cycle the FIFO is not full, and clear that slot in the same cycle.
REQ-016 SHALL give PRESS latency of exactly 2 clocks with FIFO empty and no lower-index slot pending: pbtn_db sampled high at edge N gives evt_valid high after edge N+2.
REQ-017 SHALL present evt_valid = FIFO not empty, with evt_btn/evt_type from the head entry; pop on evt_valid and evt_ready.
REQ-018 SHALL keep evt_valid, evt_btn and evt_type stable while evt_valid=1 and evt_ready=0.
REQ-019 SHALL keep entries in slots while the FIFO is full (backpressure); no event is lost at the FIFO.
REQ-020 SHALL allow simultaneous push and pop when full.
REQ-021 SHALL clear evt_overflow on ovf_clr, except when a drop occurs in the same cycle, in which case evt_overflow is set.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear: all FSMs to IDLE, counters, tick divider, prev_db, slots, FIFO pointers, evt_valid, evt_btn, evt_type and evt_overflow.
REQ-023 SHALL emit a PRESS for a button held through reset release, because prev_db resets to 0.
REQ-024 SHALL discard events that are in flight when reset asserts mid-operation.

Structure
REQ-025 SHALL place the evt_type encodings, the FSM state encoding, FIFO depth (4) and the event width (5 bits: btn+type) in package btn_event_pkg.
REQ-026 SHALL implement the FIFO as sub-module btn_event_fifo (FWFT, full/empty flags, async active-low reset).

Verification
REQ-027 SHALL verify the following with SIMULATE=1, LONG_PRESS_TICKS=4 and REPEAT_RATE_TICKS=2:
- Press btn2, evt_ready=1 -> evt_valid after 2 clocks; btn=2, type=00; release -> btn=2, type=01.
- Hold btn3 -> PRESS, then LONG after 4 ticks, then REPEAT every 2 ticks; btn5 with REPEAT_MASK bit cleared -> LONG only, no REPEAT.
- Press btn1 and btn4 in the same cycle -> btn1 PRESS delivered before btn4 PRESS; btn0 toggling -> no events.
- evt_ready=0, press/release btn1..btn4 -> FIFO fills to 4 and outputs stay stable; repeat a btn while its slot is full -> evt_overflow=1; ovf_clr -> 0.
- Assert reset_n low while btn2 is in LONG with 3 events queued -> evt_valid=0; on release of reset with btn2 still held -> single PRESS event.
